// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane pipeline register with per-lane valid, global flush and per-lane kill.
// Optional saturating hold/bubble counters are built when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       LANES      = 1,
    parameter int unsigned       STALL_W    = 6,
    parameter int unsigned       STAGE      = 3,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        kill,
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic [LANES-1:0]        valid_i,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [LANES-1:0]        valid_o,
    output logic [15:0]             hold_cnt_o,
    output logic [15:0]             bubble_cnt_o
);

    generate
        if (STAGE >= STALL_W || LANES < 1) begin : g_param_check
            $fatal(1, "pipe_stage_reg: requires STAGE < STALL_W and LANES >= 1");
        end
    endgenerate

    logic stall_self;
    logic stall_next;
    logic unused_stall;

    assign stall_self   = stall[STAGE];
    assign unused_stall = ^stall;

    // The last stage has no successor, so its stall always produces a bubble.
    generate
        if (STAGE + 1 < STALL_W) begin : g_next
            assign stall_next = stall[STAGE+1];
        end else begin : g_last
            assign stall_next = 1'b0;
        end
    endgenerate

    logic do_bubble;
    logic do_load;

    assign do_bubble = flush | (stall_self & ~stall_next);
    assign do_load   = ~flush & ~stall_self;

    // Incoming word with killed or invalid lanes replaced by the bubble value.
    logic [LANES*DATA_W-1:0] load_data;
    logic [LANES-1:0]        load_valid;

    always_comb begin
        load_valid = valid_i & ~kill;
        load_data  = {LANES{BUBBLE_VAL}};
        for (int unsigned k = 0; k < LANES; k++) begin
            if (load_valid[k]) begin
                load_data[k*DATA_W +: DATA_W] = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Datapath register; hold is the implicit else.
    always_ff @(posedge clk) begin
        if (rst || do_bubble) begin
            data_o  <= {LANES{BUBBLE_VAL}};
            valid_o <= '0;
        end else if (do_load) begin
            data_o  <= load_data;
            valid_o <= load_valid;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             do_hold;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    assign do_hold = ~flush & stall_self & stall_next;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (do_hold && hold_cnt_q != CNT_MAX) begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
            if (do_bubble && bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hold_cnt_o   = hold_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign hold_cnt_o   = 16'h0000;
    assign bubble_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 2-lane STAGE=3 instance and a 1-lane last-stage instance with a
// non-zero bubble value share clk/rst/stall/flush; expected results flow through a queue.
module tb_pipe_stage_reg;
    localparam int unsigned DW = 64;
    localparam int unsigned LN = 2;
    localparam int unsigned SW = 6;
    localparam logic [DW-1:0] BV_L = 64'h0000_0000_0000_0BAD;
`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [SW-1:0]    stall;
    logic             flush;
    logic [LN-1:0]    kill;
    logic [LN*DW-1:0] data_i;
    logic [LN-1:0]    valid_i;
    logic [LN*DW-1:0] data_o;
    logic [LN-1:0]    valid_o;
    logic [15:0]      hold_cnt, bub_cnt;
    logic [DW-1:0]    l_data;
    logic [0:0]       l_valid;
    logic [15:0]      l_hold, l_bub;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .STALL_W(SW), .STAGE(3), .BUBBLE_VAL('0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .kill(kill),
        .data_i(data_i), .valid_i(valid_i), .data_o(data_o), .valid_o(valid_o),
        .hold_cnt_o(hold_cnt), .bubble_cnt_o(bub_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .LANES(1), .STALL_W(SW), .STAGE(5), .BUBBLE_VAL(BV_L)) dut_last (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .kill(kill[0:0]),
        .data_i(data_i[DW-1:0]), .valid_i(valid_i[0:0]), .data_o(l_data), .valid_o(l_valid),
        .hold_cnt_o(l_hold), .bubble_cnt_o(l_bub)
    );

    typedef struct {
        logic [LN*DW-1:0] d;
        logic [LN-1:0]    v;
        logic [15:0]      h;
        logic [15:0]      b;
        logic [DW-1:0]    ld;
        logic             lv;
        logic [15:0]      lb;
    } exp_t;

    exp_t q[$];
    exp_t m;
    exp_t e;
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic logic [15:0] inc_sat(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // Drive one cycle of inputs and push the state both registers must show after the edge.
    task automatic drive(input logic r, input logic [SW-1:0] st, input logic fl,
                         input logic [LN-1:0] kl, input logic [LN*DW-1:0] d, input logic [LN-1:0] v);
        rst = r; stall = st; flush = fl; kill = kl; data_i = d; valid_i = v;
        if (r) begin
            m.d = '0; m.v = '0; m.h = '0; m.b = '0; m.ld = BV_L; m.lv = 1'b0; m.lb = '0;
        end else begin
            if (fl || (st[3] && !st[4])) begin
                m.d = '0; m.v = '0;
                if (PERF) m.b = inc_sat(m.b);
            end else if (!st[3]) begin
                for (int k = 0; k < LN; k++) begin
                    m.v[k] = v[k] & ~kl[k];
                    m.d[k*DW +: DW] = m.v[k] ? d[k*DW +: DW] : 64'h0;
                end
            end else begin
                if (PERF) m.h = inc_sat(m.h);
            end
            if (fl || st[5]) begin
                m.ld = BV_L; m.lv = 1'b0;
                if (PERF) m.lb = inc_sat(m.lb);
            end else begin
                m.lv = v[0] & ~kl[0];
                m.ld = m.lv ? d[DW-1:0] : BV_L;
            end
        end
        q.push_back(m);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'b000000, 1'b0, 2'b00, {64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001}, 2'b11);
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL reset[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lh=%0d lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lh=0 lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_hold, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 6'b000000, 1'b0, 2'b00, {64'(i + 100), 64'h1234 + 64'(i)}, 2'b11);
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL load[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

    task automatic test_bubble_hold();
        logic [SW-1:0] st_tab [6] = '{6'b000000, 6'b001111, 6'b000000, 6'b111111, 6'b111111, 6'b111111};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, st_tab[i], 1'b0, 2'b00, (i == 0 || i == 2) ? {64'hBCDE, 64'hABCD} : {64'h5555, 64'h7777}, 2'b11);
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL bubble_hold[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

    task automatic test_flush();
        logic [SW-1:0] st_tab [4] = '{6'b000000, 6'b111111, 6'b111111, 6'b000000};
        logic          fl_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, st_tab[i], fl_tab[i], 2'b00, {64'h9999, 64'hABCD}, 2'b11);
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL flush[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

    task automatic test_kill();
        logic [SW-1:0] st_tab [4] = '{6'b000000, 6'b111111, 6'b000000, 6'b000000};
        logic [LN-1:0] kl_tab [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
        logic [LN-1:0] v_tab  [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, st_tab[i], 1'b0, kl_tab[i], (i == 0) ? {64'h22, 64'h11} : {64'h44, 64'h33}, v_tab[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL kill[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        logic          r_tab  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [SW-1:0] st_tab [4] = '{6'b000000, 6'b111111, 6'b111111, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            drive(r_tab[i], st_tab[i], 1'b0, 2'b00, {64'hF00D + 64'(i), 64'hCAFE + 64'(i)}, 2'b11);
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL reset_mid_stall[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, SW'($urandom), ($urandom_range(0, 7) == 0), LN'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, LN'($urandom));
            @(posedge clk); #1;
            e = q.pop_front();
            n_run++;
            if (data_o !== e.d || valid_o !== e.v || hold_cnt !== e.h || bub_cnt !== e.b ||
                l_data !== e.ld || l_valid !== e.lv || l_hold !== 16'h0 || l_bub !== e.lb) begin
                n_fail++;
                $display("FAIL random[%0d]: got d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d want d=%h v=%b h=%0d b=%0d ld=%h lv=%b lb=%0d",
                         i, data_o, valid_o, hold_cnt, bub_cnt, l_data, l_valid, l_bub, e.d, e.v, e.h, e.b, e.ld, e.lv, e.lb);
            end
        end
    endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
    task automatic test_saturation();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, 6'b111111, 1'b0, 2'b00, {64'h1, 64'h2}, 2'b11);
            @(posedge clk); #1;
            e = q.pop_front();
            if (i % 8192 == 0 || i >= 65530) begin
                n_run++;
                if (hold_cnt !== e.h || bub_cnt !== e.b || l_bub !== e.lb || data_o !== e.d || valid_o !== e.v) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: got h=%h b=%h lb=%h d=%h v=%b want h=%h b=%h lb=%h d=%h v=%b",
                             i, hold_cnt, bub_cnt, l_bub, data_o, valid_o, e.h, e.b, e.lb, e.d, e.v);
                end
            end
        end
        n_run++;
        if (hold_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturation_final: hold_cnt=%h want ffff", hold_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_bubble_hold();
        test_flush();
        test_kill();
        test_reset_mid_stall();
        test_random();
`ifdef PIPE_STAGE_PERF_CNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, multi-lane pipeline register for the five-stage CPU and its successors. It replaces hand-written per-stage registers: one instance per stage boundary, with stage position selected by parameter. It adds per-lane valid tracking, a global flush, a per-lane kill mask for squashing younger lanes, and optional stall/bubble performance counters. Stall semantics follow the Ctrl stall vector: a stage that stops while its successor runs emits a bubble.

Parameters:
DATA_W, 64, payload width per lane in bits (inst, result, regc addr/write, op, mem addr/data packed by the instantiating stage).
LANES, 1, number of parallel issue lanes (1..4).
STALL_W, 6, width of the Ctrl stall vector.
STAGE, 3, index of this register's own stall bit; the successor bit is STAGE+1.
BUBBLE_VAL, 0, DATA_W-bit value driven on a lane's data when that lane holds a bubble.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  STALL_W  stall vector from Ctrl; 1 = Stop.
flush  in  1  squash all lanes (exception/redirect).
kill  in  LANES  per-lane squash of the incoming word; sampled only on load cycles.
data_i  in  LANES*DATA_W  incoming payload; lane k occupies bits [k*DATA_W +: DATA_W].
valid_i  in  LANES  incoming lane valid.
data_o  out  LANES*DATA_W  registered payload.
valid_o  out  LANES  registered lane valid.
hold_cnt_o  out  16  saturating count of hold cycles (optional feature).
bubble_cnt_o  out  16  saturating count of inserted bubbles (optional feature).

Behaviour:
- Reset: when rst=1 at a rising edge, every lane goes to data_o=BUBBLE_VAL and valid_o=0. Both counters go to 0. Reset overrides all other inputs.
- Stage-local signals: s = stall[STAGE]; n = stall[STAGE+1]. When STAGE = STALL_W-1, n is constant 0.
- Per-edge action, in priority order:
  1. rst: reset, as above.
  2. flush=1: all lanes become bubbles (data_o=BUBBLE_VAL, valid_o=0), regardless of stall.
  3. s=0 (load): lane k takes data_o=data_i[k], valid_o=valid_i[k] & ~kill[k]. If kill[k]=1 or valid_i[k]=0, lane k's data_o=BUBBLE_VAL. A lane with valid_o=0 must never show non-bubble data.
  4. s=1, n=0 (bubble): all lanes become bubbles.
  5. s=1, n=1 (hold): all outputs keep their values; kill is ignored.
- Latency: 1 cycle from data_i to data_o on a load. There is no combinational path from any input to any output.
- Lanes are independent except through flush, stall and rst, which act on every lane at once.
- Simultaneous flush and hold: flush wins. The held contents are discarded.
- Reset mid-stall: reset wins. The register leaves reset empty, and the next load takes data_i directly.
- The outputs are registers only. No downstream enable gating is required, because valid_o=0 plus BUBBLE_VAL guarantees a harmless NOP.
- Elaboration check: STAGE < STALL_W and LANES >= 1; a violation is a fatal elaboration error.

Optional Feature:
Macro PIPE_STAGE_PERF_CNT_EN.
- Defined: hold_cnt_o increments by 1 on each hold edge (case 5). bubble_cnt_o increments by 1 on each edge taking case 2 or case 4. Both counters saturate at 16'hFFFF and clear only on rst.
- Not defined: both ports are tied to 16'h0000, no counter flops are built, and the datapath behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 cycles with data_i=64'hDEAD_BEEF_0000_0001, valid_i=1 -> data_o=0 and valid_o=0 throughout; counters read 0.
2. Load: stall=6'b000000, data_i=64'h1234, valid_i=1 -> data_o=64'h1234 and valid_o=1 one edge later; a new value each cycle streams through with 1-cycle latency.
3. Bubble vs hold (STAGE=3):
   - stall=6'b001111 for 1 cycle -> data_o=0, valid_o=0, bubble_cnt=1.
   - stall=6'b111111 for 3 cycles after loading 64'hABCD -> data_o holds 64'hABCD, valid_o holds 1, hold_cnt=3.
4. Flush priority: hold asserted with 64'hABCD latched and flush=1 -> next edge data_o=0, valid_o=0; bubble_cnt increments.
5. Kill (LANES=2):
   - Load lane0=64'h11, lane1=64'h22, kill=2'b10 -> lane0 gives 64'h11 with valid=1; lane1 gives 0 with valid=0.
   - Same kill during hold -> no change.
6. Saturation (macro defined): hold for 65540 cycles -> hold_cnt_o=16'hFFFF, with no wrap to 0.
